accel_frame_tx: RTL and testbench

//   Downstream of the G-sensor SPI reader, upstream of the UART transmitter.

---
 rtl/accel_frame_tx.sv | 155 +++++++++++++++
 tb/tb_accel_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/accel_frame_tx.sv
// Serialises one 6-byte accelerometer burst into the 16-char ASCII frame
// "XXXX,YYYY,ZZZZ\r\n" and hands it to the UART one byte at a time.
module accel_frame_tx #(
  parameter logic [7:0] SEP_CHAR = 8'h2C,
  parameter int         DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [47:0]       sample_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {F_IDLE = 1'b0, F_SEND = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [47:0]       cur, cur_nxt;
  logic [47:0]       pend, pend_nxt;
  logic              pend_vld, pend_vld_nxt;
  logic [3:0]        idx, idx_nxt;
  logic              tx_valid_nxt;
  logic [7:0]        tx_data_nxt;
  logic [DROP_W-1:0] drop_cnt_nxt;
  logic              xfer;
  logic              pend_taken;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    hex_char = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  // Axes arrive low byte first on the bus; each is printed as {hi,lo}.
  function automatic logic [7:0] frame_char(input logic [47:0] s, input logic [3:0] i);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    x = {s[39:32], s[47:40]};
    y = {s[23:16], s[31:24]};
    z = {s[7:0],   s[15:8]};
    case (i)
      4'd0:    frame_char = hex_char(x[15:12]);
      4'd1:    frame_char = hex_char(x[11:8]);
      4'd2:    frame_char = hex_char(x[7:4]);
      4'd3:    frame_char = hex_char(x[3:0]);
      4'd4:    frame_char = SEP_CHAR;
      4'd5:    frame_char = hex_char(y[15:12]);
      4'd6:    frame_char = hex_char(y[11:8]);
      4'd7:    frame_char = hex_char(y[7:4]);
      4'd8:    frame_char = hex_char(y[3:0]);
      4'd9:    frame_char = SEP_CHAR;
      4'd10:   frame_char = hex_char(z[15:12]);
      4'd11:   frame_char = hex_char(z[11:8]);
      4'd12:   frame_char = hex_char(z[7:4]);
      4'd13:   frame_char = hex_char(z[3:0]);
      4'd14:   frame_char = 8'h0D;
      default: frame_char = 8'h0A;
    endcase
  endfunction

  assign xfer = tx_valid & tx_ready;
  assign busy = (state == F_SEND) | pend_vld;

  // Next-state, frame sequencing and pending-sample bookkeeping.
  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    idx_nxt      = idx;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    drop_cnt_nxt = drop_cnt;
    pend_taken   = 1'b0;

    case (state)
      F_IDLE: begin
        if (pend_vld) begin
          cur_nxt      = pend;
          pend_vld_nxt = 1'b0;
          pend_taken   = 1'b1;
          idx_nxt      = 4'd0;
          state_nxt    = F_SEND;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = frame_char(pend, 4'd0);
        end else if (sample_valid) begin
          cur_nxt      = sample_data;
          idx_nxt      = 4'd0;
          state_nxt    = F_SEND;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = frame_char(sample_data, 4'd0);
        end else begin
          tx_valid_nxt = 1'b0;
        end
      end
      F_SEND: begin
        if (xfer) begin
          if (idx == 4'd15) begin
            state_nxt    = F_IDLE;
            tx_valid_nxt = 1'b0;
            idx_nxt      = 4'd0;
          end else begin
            idx_nxt     = idx + 4'd1;
            tx_data_nxt = frame_char(cur, idx + 4'd1);
          end
        end else begin
          tx_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = F_IDLE;
        tx_valid_nxt = 1'b0;
      end
    endcase

    // A sample that cannot start a frame right now is parked; an unsent one is overwritten.
    if (sample_valid && !((state == F_IDLE) && !pend_vld)) begin
      pend_nxt     = sample_data;
      pend_vld_nxt = 1'b1;
      if (pend_vld && !pend_taken && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt_nxt = drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_nxt = drop_cnt;
      end
    end else begin
      pend_nxt = pend_nxt;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= F_IDLE;
      cur      <= 48'h0;
      pend     <= 48'h0;
      pend_vld <= 1'b0;
      idx      <= 4'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      drop_cnt <= {DROP_W{1'b0}};
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      idx      <= idx_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_accel_frame_tx.sv
// Randomised scoreboard bench for accel_frame_tx: a frame-level model queues
// expected characters, a negedge monitor checks every handshake and status output.
module tb_accel_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_data = 48'h0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  accel_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  byte         exp_q[$];
  bit          m_active = 1'b0;
  int          m_left = 0;
  bit          m_pend_vld = 1'b0;
  logic [47:0] m_pend = 48'h0;
  int          m_drop = 0;
  bit          m_took;
  int          ready_mode = 0;
  string       hexs = "0123456789ABCDEF";

  function automatic void push_frame(input logic [47:0] s);
    logic [15:0] ax[3];
    ax[0] = {s[39:32], s[47:40]};
    ax[1] = {s[23:16], s[31:24]};
    ax[2] = {s[7:0],   s[15:8]};
    for (int a = 0; a < 3; a++) begin
      for (int n = 3; n >= 0; n--) exp_q.push_back(hexs[int'((ax[a] >> (4*n)) & 16'hF)]);
      if (a < 2) exp_q.push_back(8'h2C);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Model: one frame at a time, one pending slot, one idle cycle between frames
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_left = 0; m_pend_vld = 1'b0; m_drop = 0;
      exp_q.delete();
    end else begin
      m_took = 1'b0;
      if (m_active) begin
        if (tx_ready) m_left--;
        if (m_left == 0) m_active = 1'b0;
      end else if (m_pend_vld) begin
        push_frame(m_pend); m_pend_vld = 1'b0; m_active = 1'b1; m_left = 16;
      end else if (sample_valid) begin
        push_frame(sample_data); m_took = 1'b1; m_active = 1'b1; m_left = 16;
      end
      if (sample_valid && !m_took) begin
        if (m_pend_vld && m_drop < 255) m_drop++;
        m_pend = sample_data;
        m_pend_vld = 1'b1;
      end
    end
  end

  // Monitor
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("tx_valid", tx_valid, m_active);
      check("busy", busy, m_active || m_pend_vld);
      check("drop_cnt", drop_cnt, m_drop);
      if (stall_prev && tx_valid) check("stall_stable", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_char", tx_data, 64'hFFFF);
        else check("char", tx_data, exp_q.pop_front());
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = ready 1-of-3, other = never ready
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 2) == 0);
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic pulse(input logic [47:0] d);
    @(posedge clk); #2;
    sample_valid = 1'b1; sample_data = d;
    @(posedge clk); #2;
    sample_valid = 1'b0; sample_data = {$urandom(), $urandom()};
  endtask

  task automatic wait_done(input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #3;
      if (!m_active && !m_pend_vld && !sample_valid) begin hit = 1'b1; break; end
    end
    check(nm, hit, 1'b1);
  endtask

  task automatic wait_left(input int k, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (m_active && m_left == k) begin hit = 1'b1; break; end
    end
    check(nm, hit, 1'b1);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    @(posedge clk); #2 rst_n = 1'b1;

    // T1: fixed sample, always ready
    ready_mode = 0;
    pulse({8'h34, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h01});
    wait_done("t1_done");

    // T2: same sample with random stalls
    ready_mode = 1;
    pulse({8'h34, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h01});
    wait_done("t2_done");

    // T3: three samples during one frame -> two drops
    ready_mode = 0;
    base = m_drop;
    pulse(48'hA1A2A3A4A5A6);
    repeat (2) @(posedge clk);
    pulse(48'hB1B2B3B4B5B6);
    pulse(48'hC1C2C3C4C5C6);
    pulse(48'hD1D2D3D4D5D6);
    wait_done("t3_done");
    check("t3_drop", drop_cnt, base + 2);

    // T4: sample on the LF transfer edge
    base = m_drop;
    pulse(48'h0102030405E6);
    wait_left(1, "t4_reach_lf");
    sample_valid = 1'b1; sample_data = 48'hF0E1D2C3B4A5;
    @(posedge clk); #2;
    sample_valid = 1'b0;
    @(negedge clk); check("t4_gap", tx_valid, 1'b0);
    @(negedge clk); check("t4_restart", tx_valid, 1'b1);
    wait_done("t4_done");
    check("t4_drop", drop_cnt, base);

    // Random traffic with random stalls
    ready_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      sample_valid = ($urandom_range(0, 19) == 0);
      sample_data  = {$urandom(), $urandom()};
    end
    @(posedge clk); #2 sample_valid = 1'b0;
    wait_done("rand_done");

    // Drop counter saturation
    ready_mode = 2;
    pulse(48'h123456789ABC);
    for (int k = 0; k < 300; k++) pulse({$urandom(), $urandom()});
    @(negedge clk);
    check("sat_drop", drop_cnt, 8'hFF);
    ready_mode = 0;
    wait_done("sat_done");

    // T5: reset after 7th accepted character
    pulse(48'h5566778899AA);
    wait_left(9, "t5_reach_7");
    #1 rst_n = 1'b0;
    #1;
    check("t5_tx_valid", tx_valid, 1'b0);
    check("t5_tx_data", tx_data, 8'h00);
    check("t5_busy", busy, 1'b0);
    check("t5_drop", drop_cnt, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2 check("t5_quiet", tx_valid, 1'b0);
    pulse(48'h0F1E2D3C4B5A);
    wait_done("t5_recover");

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
